// File: rtl/phase_sequencer_pkg.sv
// Shared types and constants for the instruction phase sequencer.
package phase_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DEC, S_EXE, S_MEM, S_WB, S_NXT, S_HALTED
  } state_t;

  // branch_opcode[1:0] encodings
  localparam logic [1:0] BR_JMP = 2'b00;
  localparam logic [1:0] BR_JR  = 2'b01;
  localparam logic [1:0] BR_BEQ = 2'b10;
  localparam logic [1:0] BR_BLT = 2'b11;

  // branch_opcode bit that marks a branch/jump as present
  localparam int BR_VALID = 2;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/phase_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer and instruction memory.
interface phase_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ready, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_data);
endinterface

// File: rtl/phase_sequencer_next_pc_sel.sv
// Branch-taken decision and next-PC mux, evaluated during NXT.
module phase_sequencer_next_pc_sel
  import phase_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [3:0]  branch_opcode,
  input  logic [31:0] br_target,
  input  logic        cond_zero,
  input  logic        cond_lt,
  output logic [31:0] next_pc
);

  logic taken;
  logic br_unused;

  // bit3 of branch_opcode carries no meaning for PC selection
  assign br_unused = branch_opcode[3];

  // jumps always redirect; conditional branches follow the ALU flags
  always_comb begin
    taken = 1'b0;
    if (branch_opcode[BR_VALID]) begin
      case (branch_opcode[1:0])
        BR_JMP, BR_JR: taken = 1'b1;
        BR_BEQ:        taken = cond_zero;
        BR_BLT:        taken = cond_lt;
        default:       taken = 1'b0;
      endcase
    end
    next_pc = taken ? br_target : pc + PC_INC;
  end

endmodule

// File: rtl/phase_sequencer.sv
// Fetch/phase sequencer: owns PC and IR, fetches from imem, and emits one
// registered strobe per pipeline phase to clock the control unit.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  phase_sequencer_if.master  imem,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic [31:0]        pc,
  output logic               IF_clk,
  output logic               ID_clk,
  output logic               ALU_clk,
  output logic               MEM_clk,
  output logic               RB_BR_clk,
  input  logic               halt,
  input  logic [3:0]         branch_opcode,
  input  logic [31:0]        br_target,
  input  logic               cond_zero,
  input  logic               cond_lt,
  output logic               running,
  output logic               halted,
  output logic               fault
);

  localparam int CW = $clog2(FETCH_TIMEOUT + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   pc_n, instr_n, nxt_pc;
  logic          halted_n, fault_n;
  logic [4:0]    stb_n;  // {IF, ID, ALU, MEM, RB_BR}, set on entry to each phase

  phase_sequencer_next_pc_sel u_next_pc_sel (
    .pc            (pc),
    .branch_opcode (branch_opcode),
    .br_target     (br_target),
    .cond_zero     (cond_zero),
    .cond_lt       (cond_lt),
    .next_pc       (nxt_pc)
  );

  assign opcode         = instr[31:26];
  assign imem.imem_addr = pc;
  assign imem.imem_req  = (state == S_FETCH);
  assign running        = (state != S_IDLE) && (state != S_HALTED);

  // next-state, datapath updates and strobe for the phase being entered
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pc_n     = pc;
    instr_n  = instr;
    halted_n = halted;
    fault_n  = fault;
    stb_n    = '0;
    case (state)
      S_IDLE: if (start) begin
        state_n  = S_FETCH;
        cnt_n    = '0;
        stb_n[4] = 1'b1;
      end
      S_FETCH: begin
        if (imem.imem_ready) begin
          instr_n  = imem.imem_data;
          state_n  = S_DEC;
          stb_n[3] = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == CW'(FETCH_TIMEOUT)) begin
            fault_n  = 1'b1;
            halted_n = 1'b1;
            state_n  = S_HALTED;
          end
        end
      end
      S_DEC: begin state_n = S_EXE; stb_n[2] = 1'b1; end
      S_EXE: begin state_n = S_MEM; stb_n[1] = 1'b1; end
      S_MEM: begin state_n = S_WB;  stb_n[0] = 1'b1; end
      S_WB:  state_n = S_NXT;
      S_NXT: begin
        // halt wins over any branch; PC is left pointing at the halting instr
        if (halt) begin
          halted_n = 1'b1;
          state_n  = S_HALTED;
        end else begin
          pc_n     = nxt_pc;
          cnt_n    = '0;
          state_n  = S_FETCH;
          stb_n[4] = 1'b1;
        end
      end
      S_HALTED: state_n = S_HALTED;
      default:  state_n = S_IDLE;
    endcase
  end

  // state, PC/IR and registered strobes; reset suppresses any strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      pc     <= RESET_PC;
      instr  <= '0;
      halted <= 1'b0;
      fault  <= 1'b0;
      {IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk} <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pc     <= pc_n;
      instr  <= instr_n;
      halted <= halted_n;
      fault  <= fault_n;
      {IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk} <= stb_n;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios plus random
// traffic, all compared every cycle against a timeline-based reference model.
module tb_phase_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO     = 16;

  logic        clk = 1'b0;
  logic        rst, start, halt, cond_zero, cond_lt;
  logic [3:0]  branch_opcode;
  logic [31:0] br_target;
  logic [31:0] instr, pc;
  logic [5:0]  opcode;
  logic        IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk;
  logic        running, halted, fault;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  phase_sequencer_if bus ();

  phase_sequencer #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TO)) dut (
    .clk (clk), .rst (rst), .start (start), .imem (bus),
    .instr (instr), .opcode (opcode), .pc (pc),
    .IF_clk (IF_clk), .ID_clk (ID_clk), .ALU_clk (ALU_clk),
    .MEM_clk (MEM_clk), .RB_BR_clk (RB_BR_clk),
    .halt (halt), .branch_opcode (branch_opcode), .br_target (br_target),
    .cond_zero (cond_zero), .cond_lt (cond_lt),
    .running (running), .halted (halted), .fault (fault)
  );

  always #5 clk = ~clk;

  // Reference model: an instruction is a timeline measured from FETCH entry.
  // m_t = cycles since FETCH entry, m_r = cycle on which ready arrived (-1 = none yet).
  // Phase strobes fall at r+1..r+4 and the PC decision at r+5.
  int          m_mode;  // 0 idle, 1 running, 2 halted
  int          m_t, m_r;
  logic [31:0] m_pc, m_instr;
  logic        m_halted, m_fault;

  function automatic bit br_taken(logic [3:0] op, logic z, logic lt);
    if (!op[2]) return 1'b0;
    if (op[1:0] == 2'b10) return z;
    if (op[1:0] == 2'b11) return lt;
    return 1'b1;
  endfunction

  function automatic bit at(int k);
    return (m_mode == 1) && (m_r >= 0) && (m_t == m_r + k);
  endfunction

  task model_step();
    if (rst) begin
      m_mode = 0; m_t = 0; m_r = -1; m_pc = RST_PC; m_instr = '0;
      m_halted = 1'b0; m_fault = 1'b0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_t = 0; m_r = -1; end
    end else if (m_mode == 1) begin
      if (m_r < 0) begin
        if (bus.imem_ready) begin
          m_instr = bus.imem_data;
          m_r = m_t;
        end else if (m_t + 1 >= TO) begin
          m_fault = 1'b1; m_halted = 1'b1; m_mode = 2;
        end
      end else if (m_t == m_r + 5) begin
        if (halt) begin
          m_halted = 1'b1; m_mode = 2;
        end else begin
          m_pc = br_taken(branch_opcode, cond_zero, cond_lt) ? br_target : m_pc + 32'd4;
          m_t = -1; m_r = -1;
        end
      end
      m_t++;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task check_all();
    chk("running",   running,       m_mode == 1);
    chk("imem_req",  bus.imem_req,  (m_mode == 1) && (m_r < 0));
    chk("IF_clk",    IF_clk,        (m_mode == 1) && (m_t == 0));
    chk("ID_clk",    ID_clk,        at(1));
    chk("ALU_clk",   ALU_clk,       at(2));
    chk("MEM_clk",   MEM_clk,       at(3));
    chk("RB_BR_clk", RB_BR_clk,     at(4));
    chk("pc",        pc,            m_pc);
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("instr",     instr,         m_instr);
    chk("opcode",    opcode,        m_instr[31:26]);
    chk("halted",    halted,        m_halted);
    chk("fault",     fault,         m_fault);
  endtask

  // model advances on the same edge as the DUT
  always @(posedge clk) model_step();

  // every-cycle comparison, away from the active edge
  always @(negedge clk) if (chk_en) check_all();

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_if(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (IF_clk !== 1'b1 && n < 40);
    n_vec++;
    if (IF_clk !== 1'b1) begin
      n_err++;
      $display("FAIL %s: IF_clk not seen within 40 cycles", nm);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; cond_zero = 1'b0; cond_lt = 1'b0;
    branch_opcode = 4'b0; br_target = '0;
    bus.imem_ready = 1'b0; bus.imem_data = '0;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    // reset state
    chk("lit_rst_pc", pc, RST_PC);
    chk("lit_rst_instr", instr, 32'h0);
    chk("lit_rst_req", bus.imem_req, 1'b0);
    chk("lit_rst_strobes", {IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk}, 5'b0);

    // zero-wait memory: 6-cycle instruction period, pc 0 -> 4 -> 8
    rst = 1'b0; bus.imem_ready = 1'b1; bus.imem_data = 32'h1234_5678; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("lit_if1", IF_clk, 1'b1);
    chk("lit_pc0", pc, 32'h0);
    tick(1);
    chk("lit_id1", ID_clk, 1'b1);
    tick(5);
    chk("lit_if2", IF_clk, 1'b1);
    chk("lit_pc4", pc, 32'h4);
    tick(6);
    chk("lit_pc8", pc, 32'h8);

    // ready three cycles late
    bus.imem_ready = 1'b0;
    tick(3);
    chk("lit_req_wait", bus.imem_req, 1'b1);
    bus.imem_ready = 1'b1; bus.imem_data = 32'hA5A5_0001;
    tick(1);
    chk("lit_id_late", ID_clk, 1'b1);
    chk("lit_instr_late", instr, 32'hA5A5_0001);
    chk("lit_opcode_late", opcode, 6'b101001);

    // BEQ taken then not taken
    branch_opcode = 4'b0110; br_target = 32'h40; cond_zero = 1'b1;
    wait_if("beq_taken_if");
    chk("lit_beq_taken", bus.imem_addr, 32'h40);
    cond_zero = 1'b0;
    wait_if("beq_not_if");
    chk("lit_beq_not", pc, 32'h44);

    // halt with simultaneous jump: halt wins
    halt = 1'b1; branch_opcode = 4'b0100; br_target = 32'h80;
    tick(8);
    chk("lit_halt_halted", halted, 1'b1);
    chk("lit_halt_pc", pc, 32'h44);
    chk("lit_halt_running", running, 1'b0);
    start = 1'b1;
    tick(3);
    start = 1'b0;
    chk("lit_halt_start_ign", halted, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0; halt = 1'b0; branch_opcode = 4'b0;

    // fetch timeout
    bus.imem_ready = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(15);
    chk("lit_to_early", fault, 1'b0);
    tick(1);
    chk("lit_to_fault", fault, 1'b1);
    chk("lit_to_halted", halted, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("lit_to_clr", {fault, halted}, 2'b00);
    chk("lit_to_pc", pc, RST_PC);

    // PC wrap, then reset during MEM
    bus.imem_ready = 1'b1; branch_opcode = 4'b0100; br_target = 32'hFFFF_FFFC; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_if("jmp_top_if");
    chk("lit_pc_top", pc, 32'hFFFF_FFFC);
    branch_opcode = 4'b0000;
    wait_if("wrap_if");
    chk("lit_pc_wrap", pc, 32'h0);
    tick(3);
    chk("lit_mem", MEM_clk, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("lit_rst_no_rb", RB_BR_clk, 1'b0);
    chk("lit_rst_idle", running, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 149) == 0) || (i % 400 == 0);
      start          = ($urandom_range(0, 3) == 0);
      bus.imem_ready = ($urandom_range(0, 2) != 0);
      bus.imem_data  = $urandom;
      halt           = ($urandom_range(0, 19) == 0);
      branch_opcode  = 4'($urandom_range(0, 15));
      br_target      = $urandom;
      cond_zero      = 1'($urandom_range(0, 1));
      cond_lt        = 1'($urandom_range(0, 1));
      tick(1);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
